// File: rtl/bcd_ascii_converter.sv
// Sequential double-dabble binary-to-decimal converter with ASCII output and overflow flag.
// Optional leading-zero blanking is enabled by defining BCD_ASCII_BLANK_EN.
module bcd_ascii_converter #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   ascii,
  output logic                  overflow
);

  localparam int unsigned NI = (3 * WIDTH) / 10 + 1;
  localparam int unsigned NX = (NI > DIGITS) ? NI : DIGITS;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAdd3  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  function automatic logic [8*DIGITS-1:0] ascii_reset();
    logic [8*DIGITS-1:0] r;
    for (int k = 0; k < int'(DIGITS); k++) begin
`ifdef BCD_ASCII_BLANK_EN
      r[8*k +: 8] = (k == 0) ? 8'h30 : 8'h20;
`else
      r[8*k +: 8] = 8'h30;
`endif
    end
    return r;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    op_q, op_d;
  logic [4*NI-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [8*DIGITS-1:0] ascii_q, ascii_d;
  logic                ovf_q, ovf_d;

  logic [4*NX-1:0]     bcd_ext;
  logic [8*DIGITS-1:0] ascii_c;
  logic                ovf_c;
  logic [3:0]          nib;
`ifdef BCD_ASCII_BLANK_EN
  logic                lead;
`endif

  // Zero-extend the BCD register so DIGITS > NI reads as leading zeros.
  always_comb begin
    bcd_ext            = '0;
    bcd_ext[4*NI-1:0]  = bcd_q;
    ovf_c              = 1'b0;
    for (int unsigned k = DIGITS; k < NX; k++) begin
      ovf_c = ovf_c | (|bcd_ext[4*k +: 4]);
    end
    ascii_c = '0;
    nib     = '0;
`ifdef BCD_ASCII_BLANK_EN
    lead = ~ovf_c;
`endif
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      nib                = bcd_ext[4*k +: 4];
      ascii_c[8*k +: 8]  = {4'h3, nib};
`ifdef BCD_ASCII_BLANK_EN
      if (lead && (k > 0) && (nib == 4'd0)) begin
        ascii_c[8*k +: 8] = 8'h20;
      end else begin
        lead = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ascii_d = ascii_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = value;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StAdd3;
        end
      end
      StAdd3: begin
        for (int k = 0; k < int'(NI); k++) begin
          if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
          end
        end
        state_d = StShift;
      end
      StShift: begin
        {bcd_d, op_d} = {bcd_q, op_q} << 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StAdd3;
        end
      end
      StDone: begin
        ascii_d = ascii_c;
        ovf_d   = ovf_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ascii_q <= ascii_reset();
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ascii_q <= ascii_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ascii    = ascii_q;
  assign overflow = ovf_q;

endmodule

// File: doc/bcd_ascii_converter.md
# bcd_ascii_converter

Parametrised binary-to-decimal converter producing fixed-width ASCII digit strings for text/LCD overlays. It takes a WIDTH-bit unsigned value on a start/busy/done handshake and runs sequential double-dabble, one ADD3 cycle and one SHIFT cycle per input bit. It reports overflow when the value does not fit in DIGITS characters. It sits between sensor and ADC front ends and the text-rendering blocks.

## Interface
- WIDTH, 12: input value width in bits, 1 to 32.
- DIGITS, 4: number of ASCII characters output, 1 to 10.
- clk  in  1: system clock; all logic on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: request a conversion; sampled only when busy=0.
- value  in  WIDTH: unsigned operand, captured on the edge that accepts start.
- busy  out  1: conversion in progress.
- done  out  1: one-cycle pulse; ascii and overflow are valid from this cycle.
- ascii  out  8*DIGITS: result characters, most-significant digit in the top byte.
- overflow  out  1: the value needs more than DIGITS digits; updated together with done.

## Operation
- Internal BCD register holds NI = (3*WIDTH)/10 + 1 nibbles (integer division), always enough for 2^WIDTH-1. Shift counter is ceil(log2(WIDTH)) bits.
- FSM states are IDLE, ADD3, SHIFT and DONE.
- IDLE, start=1: capture value into the shift register, clear BCD, clear the step counter, go to ADD3, set busy=1. With start=0, stay in IDLE.
- ADD3: add 3 to every nibble that is 5 or more, all nibbles in parallel in one cycle; go to SHIFT.
- SHIFT: shift {BCD, operand} left by one, with the operand MSB entering BCD bit 0.
  - Step counter equal to WIDTH-1: go to DONE.
  - Otherwise: increment the counter and return to ADD3.
- DONE, on one edge:
  - ascii byte k = 0x30 + BCD nibble k, for k < DIGITS.
  - overflow = OR of nibbles DIGITS..NI-1; it is 0 when DIGITS ≥ NI.
  - done=1, busy=0, go to IDLE.
- When overflow=1, ascii shows the low DIGITS decimal digits (truncated), never saturated.
- start while busy=1 is ignored, not queued; value changes during busy have no effect.
- ascii and overflow hold their values between conversions.

## Timing
- Reset values: busy=0, done=0, overflow=0, FSM=IDLE. Every ascii byte is 0x30, except as stated in Configuration.
- Count the start-accepting edge as edge 1. Then:
  - busy is high after edge 1.
  - done, ascii and overflow update after edge 2*WIDTH+2; busy falls on that same edge.
  - For WIDTH=12 that is edge 26, so busy is high for 25 cycles.
- done is high for exactly one cycle.
- start may be high in the done cycle and is accepted (FSM is IDLE), so back-to-back throughput is one result per 2*WIDTH+2 cycles.
- rst_n low at any point aborts the conversion:
  - Outputs return to reset values asynchronously.
  - No done pulse is issued for the aborted operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- BCD_ASCII_BLANK_EN defined: leading-zero blanking.
  - In DONE, every zero digit above the first nonzero digit is written as 0x20 (space).
  - The least-significant byte is always a digit.
  - Blanking is suppressed when overflow=1; all DIGITS characters are then shown.
  - Reset ascii value is spaces with "0" in the low byte.
- BCD_ASCII_BLANK_EN undefined: all bytes are 0x30+digit, with no blanking logic synthesised.

## Test plan
- WIDTH=12, DIGITS=4, value=4095, start for one cycle -> done after edge 26 with ascii="4095", overflow=0; busy is high for exactly 25 cycles.
- value=0 -> ascii="0000"; with BCD_ASCII_BLANK_EN, ascii="   0". value=1009 with blanking -> "1009", where the inner zeros stay visible.
- start re-pulsed with value=7 while busy during a 1234 conversion -> single done, ascii="1234", and no second done afterwards.
- start held high continuously with value alternating 5 and 999 -> done pulses every 26 cycles, ascii alternating "0005" and "0999".
- DIGITS=3, value=1234 -> ascii="234", overflow=1 (no blanking even when enabled); the next conversion of 12 -> overflow=0.
- rst_n pulsed low mid-conversion at cycle 10 -> busy=0 and ascii at its reset value immediately, no done; a new start of 321 then yields "0321".
